// File: rtl/fifo_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_reader_pkg : shared FIFO reader state encodings and defaults    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fifo_reader_pkg;

    localparam int DATA_BITS_DEFAULT = 10;
    localparam int CNT_BITS_DEFAULT  = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_ERR   = 2'd2;

endpackage : fifo_reader_pkg
`default_nettype wire

// File: rtl/fifo_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_reader : drains a FIFO between its high and low limits, with a  |
// |               fixed one-cycle read pipeline and a sticky error state |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEFAULT,
    parameter int CNT_BITS  = CNT_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] fifo_data_out,
    input  logic                 fifo_empty_out,
    input  logic                 fifo_almost_full,
    input  logic                 fifo_almost_empty,
    input  logic                 error_fifo_out,
    input  logic                 pause_in,
    input  logic                 flush_in,
    output logic                 fifo_read,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic [CNT_BITS-1:0]  read_count,
    output logic                 error_out,
    output logic                 busy_out
);

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic                 r_pending;
    logic [DATA_BITS-1:0] r_hold;
    logic [CNT_BITS-1:0]  r_count;
    logic                 r_error;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (fifo_almost_full || (flush_in && !fifo_empty_out))
                    w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                // almost_full wins over almost_empty when both are reported
                if (fifo_almost_full)
                    w_next_state = ST_DRAIN;
                else if (fifo_empty_out || (fifo_almost_empty && !flush_in))
                    w_next_state = ST_IDLE;
            end
            ST_ERR:  w_next_state = ST_ERR;
            default: w_next_state = ST_IDLE;
        endcase
        if (error_fifo_out)
            w_next_state = ST_ERR;
    end

    assign fifo_read = !reset && (r_state == ST_DRAIN) && !fifo_empty_out
                       && !pause_in && !error_fifo_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pending <= 1'b0;
            r_hold    <= '0;
            r_count   <= '0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_pending <= fifo_read;
            if (r_pending) begin
                r_hold  <= fifo_data_out;
                r_count <= r_count + CNT_BITS'(1);
            end
            if (error_fifo_out)
                r_error <= 1'b1;
        end
    end

    // FIFO data arrives the cycle after the pop, so the delivered word is
    // taken straight from the FIFO port and held afterwards; a reset in the
    // delivery cycle suppresses the pulse.
    assign valid_out  = r_pending && !reset;
    assign data_out   = valid_out ? fifo_data_out : r_hold;
    assign read_count = r_count;
    assign error_out  = r_error;
    assign busy_out   = (r_state == ST_DRAIN);

endmodule : fifo_reader
`default_nettype wire

// File: tb/tb_fifo_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fifo_reader : directed bench with a FIFO (high 6, low 2) and a    |
// |                  per-cycle behavioural reference of the reader       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fifo_reader;

    localparam int DW      = 10;
    localparam int CW      = 8;
    localparam int HI_LIM  = 6;
    localparam int LO_LIM  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] fifo_data_out = '0;
    logic          fifo_empty_out;
    logic          fifo_almost_full;
    logic          fifo_almost_empty;
    logic          error_fifo_out;
    logic          pause_in;
    logic          flush_in;
    logic          fifo_read;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [CW-1:0] read_count;
    logic          error_out;
    logic          busy_out;

    logic          wr;
    logic [DW-1:0] wr_data;
    logic          fifo_clr;
    int            occ = 0;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    fifo_reader #(.DATA_BITS(DW), .CNT_BITS(CW)) dut (
        .clk               (clk),
        .reset             (reset),
        .fifo_data_out     (fifo_data_out),
        .fifo_empty_out    (fifo_empty_out),
        .fifo_almost_full  (fifo_almost_full),
        .fifo_almost_empty (fifo_almost_empty),
        .error_fifo_out    (error_fifo_out),
        .pause_in          (pause_in),
        .flush_in          (flush_in),
        .fifo_read         (fifo_read),
        .data_out          (data_out),
        .valid_out         (valid_out),
        .read_count        (read_count),
        .error_out         (error_out),
        .busy_out          (busy_out)
    );

    // FIFO whose almost_empty reports occupancy net of a concurrent pop
    always @(posedge clk) begin
        if (fifo_clr) begin
            fq.delete();
            occ <= 0;
        end else begin
            if (fifo_read === 1'b1 && fq.size() > 0)
                fifo_data_out <= fq.pop_front();
            if (wr)
                fq.push_back(wr_data);
            occ <= fq.size();
        end
    end

    assign fifo_empty_out    = (occ == 0);
    assign fifo_almost_full  = (occ >= HI_LIM);
    assign fifo_almost_empty = ((occ - ((fifo_read === 1'b1) ? 1 : 0)) <= LO_LIM);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: draining/faulted flags, one in-flight word, delivered count
    bit            m_draining = 1'b0;
    bit            m_faulted  = 1'b0;
    bit            m_inflight = 1'b0;
    logic [DW-1:0] m_word     = '0;
    logic [DW-1:0] m_last     = '0;
    int            m_delivered = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            bit            e_valid;
            bit            e_read;
            logic [DW-1:0] e_data;
            e_valid = m_inflight && !reset;
            e_data  = e_valid ? m_word : m_last;
            e_read  = !reset && !m_faulted && m_draining && !fifo_empty_out
                      && !pause_in && !error_fifo_out;
            chk("m_fifo_read", 32'(fifo_read), 32'(e_read));
            chk("m_valid_out", 32'(valid_out), 32'(e_valid));
            chk("m_data_out",  32'(data_out),  32'(e_data));
            chk("m_read_count", 32'(read_count), 32'(m_delivered % (1 << CW)));
            chk("m_error_out", 32'(error_out), 32'(m_faulted));
            chk("m_busy_out",  32'(busy_out),  32'(m_draining && !m_faulted));
            if (reset) begin
                m_draining  = 1'b0;
                m_faulted   = 1'b0;
                m_inflight  = 1'b0;
                m_last      = '0;
                m_delivered = 0;
            end else begin
                if (e_valid) begin
                    m_last = m_word;
                    m_delivered++;
                end
                m_inflight = e_read;
                if (e_read) begin
                    if (exp_q.size() > 0) m_word = exp_q.pop_front();
                    else chk("m_exp_queue_nonempty", 32'(0), 32'(1));
                end
                if (error_fifo_out)
                    m_faulted = 1'b1;
                else if (!m_draining)
                    m_draining = fifo_almost_full || (flush_in && !fifo_empty_out);
                else if (!fifo_almost_full)
                    m_draining = !(fifo_empty_out || (fifo_almost_empty && !flush_in));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; wr = 1'b0; flush_in = 1'b0; pause_in = 1'b0;
        error_fifo_out = 1'b0; fifo_clr = 1'b1;
        exp_q.delete();
        cyc();
        cyc();
        reset = 1'b0; fifo_clr = 1'b0;
        @(negedge clk);
        chk("rst_data_out",   32'(data_out),   32'(0));
        chk("rst_valid_out",  32'(valid_out),  32'(0));
        chk("rst_read_count", 32'(read_count), 32'(0));
        chk("rst_error_out",  32'(error_out),  32'(0));
        chk("rst_busy_out",   32'(busy_out),   32'(0));
        cyc();
    endtask

    task automatic write_words(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            wr = 1'b1;
            wr_data = DW'(base + i);
            exp_q.push_back(wr_data);
            cyc();
        end
        wr = 1'b0;
    endtask

    // Leaves the caller at the negedge of the first DRAIN cycle
    task automatic wait_busy(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy_out === 1'b1) return;
            cyc();
        end
        n_checks++;
        n_errors++;
        $display("FAIL %s: busy_out got 0 expected 1 within 20 cycles", name);
    endtask

    initial begin
        int reads, valids, first, last;
        reset = 1'b1; wr = 1'b0; wr_data = '0; fifo_clr = 1'b1;
        flush_in = 1'b0; pause_in = 1'b0; error_fifo_out = 1'b0;
        cyc();
        chk_en = 1'b1;
        do_reset();

        // Burst: six words trip the high limit, four reads bring it to two
        write_words(6, 'h100);
        reads = 0; valids = 0; first = -1; last = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (fifo_read === 1'b1) begin
                reads++;
                if (first < 0) first = i;
                last = i;
            end
            if (valid_out === 1'b1) valids++;
            cyc();
        end
        chk("burst_reads", 32'(reads), 32'(4));
        chk("burst_consecutive", 32'(last - first), 32'(3));
        chk("burst_valids", 32'(valids), 32'(4));
        @(negedge clk);
        chk("burst_read_count", 32'(read_count), 32'(4));
        chk("burst_idle", 32'(busy_out), 32'(0));
        chk("burst_last_data", 32'(data_out), 32'('h103));
        cyc();

        // Flush: two resident words drained below the low limit
        do_reset();
        write_words(2, 'h2A0);
        cyc();
        flush_in = 1'b1;
        valids = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (valid_out === 1'b1) valids++;
            cyc();
        end
        flush_in = 1'b0;
        @(negedge clk);
        chk("flush_valids", 32'(valids), 32'(2));
        chk("flush_read_count", 32'(read_count), 32'(2));
        chk("flush_idle", 32'(busy_out), 32'(0));
        chk("flush_last_data", 32'(data_out), 32'('h2A1));
        cyc();

        // Pause on the second DRAIN cycle for three cycles
        do_reset();
        write_words(6, 'h050);
        wait_busy("pause_wait_busy");
        cyc();
        pause_in = 1'b1;
        @(negedge clk);
        chk("pause_trailing_valid", 32'(valid_out), 32'(1));
        chk("pause_trailing_data", 32'(data_out), 32'('h050));
        chk("pause_read_gated", 32'(fifo_read), 32'(0));
        cyc();
        @(negedge clk);
        chk("pause_no_valid_2", 32'(valid_out), 32'(0));
        cyc();
        @(negedge clk);
        chk("pause_no_valid_3", 32'(valid_out), 32'(0));
        cyc();
        pause_in = 1'b0;
        @(negedge clk);
        chk("pause_no_valid_4", 32'(valid_out), 32'(0));
        chk("pause_resume_read", 32'(fifo_read), 32'(1));
        for (int i = 0; i < 8; i++) cyc();
        @(negedge clk);
        chk("pause_read_count", 32'(read_count), 32'(4));
        cyc();

        // Error mid-DRAIN: in-flight word delivered, then sticky error
        do_reset();
        write_words(6, 'h300);
        wait_busy("err_wait_busy");
        cyc();
        error_fifo_out = 1'b1;
        @(negedge clk);
        chk("err_read_blocked", 32'(fifo_read), 32'(0));
        chk("err_inflight_valid", 32'(valid_out), 32'(1));
        chk("err_not_yet", 32'(error_out), 32'(0));
        cyc();
        error_fifo_out = 1'b0;
        @(negedge clk);
        chk("err_asserted", 32'(error_out), 32'(1));
        chk("err_busy_low", 32'(busy_out), 32'(0));
        reads = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            @(negedge clk);
            if (fifo_read === 1'b1) reads++;
        end
        chk("err_no_reads", 32'(reads), 32'(0));
        chk("err_sticky", 32'(error_out), 32'(1));
        chk("err_read_count", 32'(read_count), 32'(1));
        cyc();

        // Reset one cycle after a read: the in-flight word is discarded
        do_reset();
        write_words(2, 'h3F0);
        flush_in = 1'b1;
        wait_busy("rstmid_wait_busy");
        cyc();
        reset = 1'b1;
        flush_in = 1'b0;
        @(negedge clk);
        chk("rstmid_no_valid", 32'(valid_out), 32'(0));
        chk("rstmid_read_low", 32'(fifo_read), 32'(0));
        cyc();
        reset = 1'b0;
        valids = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (valid_out === 1'b1) valids++;
            cyc();
        end
        @(negedge clk);
        chk("rstmid_valids", 32'(valids), 32'(0));
        chk("rstmid_read_count", 32'(read_count), 32'(0));
        chk("rstmid_idle", 32'(busy_out), 32'(0));
        cyc();

        // Wrap: 257 delivered words leave the counter at 1
        do_reset();
        flush_in = 1'b1;
        write_words(257, 0);
        for (int i = 0; i < 10; i++) cyc();
        flush_in = 1'b0;
        @(negedge clk);
        chk("wrap_read_count", 32'(read_count), 32'(1));
        chk("wrap_last_data", 32'(data_out), 32'(256));
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_fifo_reader
`default_nettype wire
